// File: rtl/regfile_sb.sv
// regfile_sb: register file with an issue scoreboard (pending-producer flags).
//
// Purpose:
//   NREG x XLEN register file with two combinational read ports and one
//   write (writeback) port. Alongside the data, a pending flag per register
//   records that an issued instruction will later write it. Index 0 is
//   hardwired: always reads 0, never busy, ignores writes and issues.
//
// Ports:
//   clk                 rising-edge clock for all state
//   rst_n               asynchronous active-low reset (data, flags, count)
//   we/waddr/wdata      writeback: writes data and retires the pending flag
//   raddr1/raddr2       read indices
//   rdata1/rdata2       combinational read data (optionally forwarded)
//   rbusy1/rbusy2       read register still has a pending producer
//   issue_en/issue_addr marks issue_addr as pending
//   flush               clears every pending flag (a same-cycle issue survives)
//   pend_cnt            registered population count of the pending flags
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] waddr,
    input  logic [XLEN-1:0]         wdata,
    input  logic [$clog2(NREG)-1:0] raddr1,
    input  logic [$clog2(NREG)-1:0] raddr2,
    output logic [XLEN-1:0]         rdata1,
    output logic [XLEN-1:0]         rdata2,
    output logic                    rbusy1,
    output logic                    rbusy2,
    input  logic                    issue_en,
    input  logic [$clog2(NREG)-1:0] issue_addr,
    input  logic                    flush,
    output logic [$clog2(NREG):0]   pend_cnt
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] rf [NREG];
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;
    logic [AW:0]     cnt_nxt;
    logic            wr_hit;
    logic            iss_hit;
    logic            fwd1;
    logic            fwd2;

    // Writes and issues aimed at index 0 are dropped here, so neither rf[0]
    // nor pend[0] can ever leave its reset value.
    assign wr_hit  = we && (waddr != '0);
    assign iss_hit = issue_en && (issue_addr != '0);

    function automatic logic fwd_match(input logic          hit,
                                       input logic [AW-1:0] wa,
                                       input logic [AW-1:0] ra);
        return (BYPASS != 0) && hit && (wa == ra);
    endfunction

    assign fwd1 = fwd_match(wr_hit, waddr, raddr1);
    assign fwd2 = fwd_match(wr_hit, waddr, raddr2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_hit) begin
            rf[waddr] <= wdata;
        end
    end

    // Flag update order: flush (or the writeback retire) first, then the
    // issue, so a new producer always wins over a retiring one or a flush.
    always_comb begin
        pend_nxt = pend;
        if (flush) begin
            pend_nxt = '0;
        end else if (wr_hit) begin
            pend_nxt[waddr] = 1'b0;
        end
        if (iss_hit) begin
            pend_nxt[issue_addr] = 1'b1;
        end
    end

    // The count is recomputed from the next flag vector rather than tracked
    // incrementally, so it stays exact under flushes and idempotent issues.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    // Reads are forced to 0 during reset so a forwarded wdata cannot leak out.
    always_comb begin
        rdata1 = '0;
        if (rst_n && (raddr1 != '0)) begin
            rdata1 = fwd1 ? wdata : rf[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst_n && (raddr2 != '0)) begin
            rdata2 = fwd2 ? wdata : rf[raddr2];
        end
    end

    // A forwarded read is not busy: the value it waits for is on wdata now.
    assign rbusy1 = rst_n && (raddr1 != '0) && !fwd1 && pend[raddr1];
    assign rbusy2 = rst_n && (raddr2 != '0) && !fwd2 && pend[raddr2];

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        flush;

    logic [31:0] rdata1_b1, rdata2_b1, rdata1_b0, rdata2_b0;
    logic        rbusy1_b1, rbusy2_b1, rbusy1_b0, rbusy2_b0;
    logic [5:0]  pend_cnt_b1, pend_cnt_b0;

    int nvec = 0;
    int nerr = 0;

    regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) dut_b1 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_b1), .rdata2(rdata2_b1),
        .rbusy1(rbusy1_b1), .rbusy2(rbusy2_b1), .issue_en(issue_en),
        .issue_addr(issue_addr), .flush(flush), .pend_cnt(pend_cnt_b1)
    );

    regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(0)) dut_b0 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_b0), .rdata2(rdata2_b0),
        .rbusy1(rbusy1_b0), .rbusy2(rbusy2_b0), .issue_en(issue_en),
        .issue_addr(issue_addr), .flush(flush), .pend_cnt(pend_cnt_b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arrays of register contents and pending bits.
    logic [31:0] rf_m [32];
    bit          pend_m [32];

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            rf_m[i]   = '0;
            pend_m[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] m_rd(input int bp, input logic [4:0] ra);
        if (ra == 0) return '0;
        if (bp != 0 && we && waddr == ra) return wdata;
        return rf_m[ra];
    endfunction

    function automatic logic m_busy(input int bp, input logic [4:0] ra);
        if (ra == 0) return 1'b0;
        if (bp != 0 && we && waddr == ra) return 1'b0;
        return pend_m[ra];
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += pend_m[i] ? 1 : 0;
        return c;
    endfunction

    task automatic m_edge();
        if (we && waddr != 0) rf_m[waddr] = wdata;
        if (flush) begin
            for (int i = 0; i < 32; i++) pend_m[i] = 1'b0;
        end else if (we && waddr != 0) begin
            pend_m[waddr] = 1'b0;
        end
        if (issue_en && issue_addr != 0) pend_m[issue_addr] = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic is, input logic [4:0] ia, input logic fl,
                         input logic [4:0] r1, input logic [4:0] r2);
        we = w; waddr = wa; wdata = wd; issue_en = is; issue_addr = ia;
        flush = fl; raddr1 = r1; raddr2 = r2;
    endtask

    // Compare both instances against the model, clock once, check counts.
    task automatic step_model(input string tag);
        #1;
        chk({tag, " rdata1_b1"}, rdata1_b1, m_rd(1, raddr1));
        chk({tag, " rdata2_b1"}, rdata2_b1, m_rd(1, raddr2));
        chk({tag, " rbusy1_b1"}, rbusy1_b1, m_busy(1, raddr1));
        chk({tag, " rbusy2_b1"}, rbusy2_b1, m_busy(1, raddr2));
        chk({tag, " rdata1_b0"}, rdata1_b0, m_rd(0, raddr1));
        chk({tag, " rdata2_b0"}, rdata2_b0, m_rd(0, raddr2));
        chk({tag, " rbusy1_b0"}, rbusy1_b0, m_busy(0, raddr1));
        chk({tag, " rbusy2_b0"}, rbusy2_b0, m_busy(0, raddr2));
        @(posedge clk);
        m_edge();
        #1;
        chk({tag, " pend_cnt_b1"}, pend_cnt_b1, m_cnt());
        chk({tag, " pend_cnt_b0"}, pend_cnt_b0, m_cnt());
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        is;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] rd1;
        logic        rb1;
        logic [31:0] rd2;
        logic        rb2;
        logic [5:0]  cnt;
    } vec_t;

    function automatic vec_t mk(logic w, logic [4:0] wa, logic [31:0] wd, logic is,
                                logic [4:0] ia, logic fl, logic [4:0] r1, logic [4:0] r2,
                                logic [31:0] rd1, logic rb1, logic [31:0] rd2, logic rb2,
                                logic [5:0] cnt);
        vec_t v;
        v.we = w; v.wa = wa; v.wd = wd; v.is = is; v.ia = ia; v.fl = fl;
        v.r1 = r1; v.r2 = r2; v.rd1 = rd1; v.rb1 = rb1; v.rd2 = rd2; v.rb2 = rb2;
        v.cnt = cnt;
        return v;
    endfunction

    vec_t tbl[16];

    initial begin
        //          we wa  wdata         is ia fl r1  r2  rd1           rb1 rd2           rb2 cnt
        tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 5,  0, 32'hDEADBEEF, 0, 32'h0,        0, 0);
        tbl[1]  = mk(0, 0, 32'h0,        0, 0, 0, 5,  0, 32'hDEADBEEF, 0, 32'h0,        0, 0);
        tbl[2]  = mk(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0,  5, 32'h0,        0, 32'hDEADBEEF, 0, 0);
        tbl[3]  = mk(0, 0, 32'h0,        1, 3, 0, 3,  0, 32'h0,        0, 32'h0,        0, 1);
        tbl[4]  = mk(0, 0, 32'h0,        1, 7, 0, 3,  0, 32'h0,        1, 32'h0,        0, 2);
        tbl[5]  = mk(0, 0, 32'h0,        1, 3, 0, 3,  7, 32'h0,        1, 32'h0,        1, 2);
        tbl[6]  = mk(1, 3, 32'h33,       0, 0, 0, 3,  7, 32'h33,       0, 32'h0,        1, 1);
        tbl[7]  = mk(0, 0, 32'h0,        0, 0, 0, 3,  7, 32'h33,       0, 32'h0,        1, 1);
        tbl[8]  = mk(0, 0, 32'h0,        1, 9, 0, 9,  0, 32'h0,        0, 32'h0,        0, 2);
        tbl[9]  = mk(1, 9, 32'h99,       1, 9, 0, 9,  7, 32'h99,       0, 32'h0,        1, 2);
        tbl[10] = mk(0, 0, 32'h0,        0, 0, 0, 9,  0, 32'h99,       1, 32'h0,        0, 2);
        tbl[11] = mk(0, 0, 32'h0,        1, 4, 0, 0,  0, 32'h0,        0, 32'h0,        0, 3);
        tbl[12] = mk(0, 0, 32'h0,        1, 5, 0, 4,  5, 32'h0,        1, 32'hDEADBEEF, 0, 4);
        tbl[13] = mk(0, 0, 32'h0,        1, 12,1, 9, 12, 32'h99,       1, 32'h0,        0, 1);
        tbl[14] = mk(0, 0, 32'h0,        0, 0, 0, 12, 9, 32'h0,        1, 32'h99,       0, 1);
        tbl[15] = mk(1, 12,32'hC,        0, 0, 1, 12, 0, 32'hC,        0, 32'h0,        0, 0);
    end

    initial begin
        m_clear();
        // Reset asserted with active-looking inputs: everything must stay 0.
        rst_n = 1'b0;
        drive(1, 1, 32'h5, 1, 1, 0, 1, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("reset rdata1", rdata1_b1, 32'h0);
        chk("reset rbusy1", rbusy1_b1, 1'b0);
        chk("reset pend_cnt", pend_cnt_b1, 6'd0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset rdata1", rdata1_b1, 32'h0);
        chk("post-reset pend_cnt", pend_cnt_b1, 6'd0);

        // Directed table.
        for (int k = 0; k < 16; k++) begin
            drive(tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].is, tbl[k].ia, tbl[k].fl,
                  tbl[k].r1, tbl[k].r2);
            #1;
            chk($sformatf("tbl%0d rdata1", k), rdata1_b1, tbl[k].rd1);
            chk($sformatf("tbl%0d rbusy1", k), rbusy1_b1, tbl[k].rb1);
            chk($sformatf("tbl%0d rdata2", k), rdata2_b1, tbl[k].rd2);
            chk($sformatf("tbl%0d rbusy2", k), rbusy2_b1, tbl[k].rb2);
            chk($sformatf("tbl%0d rdata1_b0", k), rdata1_b0, m_rd(0, raddr1));
            @(posedge clk);
            m_edge();
            #1;
            chk($sformatf("tbl%0d pend_cnt", k), pend_cnt_b1, tbl[k].cnt);
            chk($sformatf("tbl%0d pend_cnt_b0", k), pend_cnt_b0, 6'(m_cnt()));
        end

        // No-forwarding instance returns the old value during a write.
        drive(1, 5, 32'h1234, 0, 0, 0, 5, 5);
        #1;
        chk("nobypass old value", rdata1_b0, 32'hDEADBEEF);
        chk("bypass new value", rdata1_b1, 32'h1234);
        step_model("nobypass");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
                  $urandom_range(0, 15) == 0,
                  5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
            step_model($sformatf("rnd%0d", n));
        end

        // Asynchronous reset with loaded registers and 3 pending.
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        step_model("pre-flush");
        drive(0, 0, 0, 1, 1, 0, 0, 0);
        step_model("iss1");
        drive(1, 2, 32'h2222, 1, 2, 0, 0, 0);
        step_model("iss2");
        drive(1, 3, 32'hA5A5, 1, 3, 0, 0, 0);
        step_model("iss3");
        chk("pre-reset pend_cnt", pend_cnt_b1, 6'd3);
        drive(1, 2, 32'h55, 1, 8, 0, 2, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async rdata1", rdata1_b1, 32'h0);
        chk("async rdata2", rdata2_b1, 32'h0);
        chk("async rbusy2", rbusy2_b1, 1'b0);
        chk("async pend_cnt", pend_cnt_b1, 6'd0);
        chk("async pend_cnt_b0", pend_cnt_b0, 6'd0);
        chk("async rdata2_b0", rdata2_b0, 32'h0);
        @(posedge clk);
        #1;
        chk("held rdata1", rdata1_b1, 32'h0);
        chk("held pend_cnt", pend_cnt_b1, 6'd0);
        m_clear();
        drive(0, 0, 0, 0, 0, 0, 2, 3);
        #1 rst_n = 1'b1;
        #1;
        chk("released rdata2", rdata2_b1, 32'h0);
        chk("released rdata1", rdata1_b1, 32'h0);
        drive(1, 2, 32'h77, 1, 6, 0, 2, 6);
        step_model("first-after-reset");
        drive(0, 0, 0, 0, 0, 0, 2, 6);
        #1;
        chk("after-reset rdata1", rdata1_b1, 32'h77);
        chk("after-reset rbusy2", rbusy2_b1, 1'b1);
        chk("after-reset pend_cnt", pend_cnt_b1, 6'd1);
        step_model("final");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameter XLEN, default 32, meaning data word width in bits.
REQ-002 SHALL provide parameter NREG, default 32, meaning register count; power of two, at least 4.
REQ-003 SHALL provide parameter BYPASS, default 1, meaning 1 enables same-cycle write-to-read forwarding and 0 disables it.
REQ-004 SHALL derive localparam AW = log2(NREG) for all address widths.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port we, input, 1 bit: writeback enable.
REQ-008 SHALL have port waddr, input, AW bits: writeback register index.
REQ-009 SHALL have port wdata, input, XLEN bits: writeback data.
REQ-010 SHALL have ports raddr1 and raddr2, input, AW bits each: read indices.
REQ-011 SHALL have ports rdata1 and rdata2, output, XLEN bits each: read data, combinational.
REQ-012 SHALL have ports rbusy1 and rbusy2, output, 1 bit each: the read register has a pending producer.
REQ-013 SHALL have port issue_en, input, 1 bit: an instruction writing issue_addr is issued.
REQ-014 SHALL have port issue_addr, input, AW bits: destination of the issued instruction.
REQ-015 SHALL have port flush, input, 1 bit: synchronously clear all pending flags.
REQ-016 SHALL have port pend_cnt, output, AW+1 bits: number of registers currently pending.

Function
REQ-017 SHALL hold NREG x XLEN data registers and NREG pending flags.
REQ-018 SHALL keep index 0 hardwired: reads return 0, busy reads 0, and writes or issues to index 0 are ignored.
REQ-019 SHALL update the data register at the clock edge when we=1 and waddr!=0: rf[waddr] <= wdata.
REQ-020 SHALL, when BYPASS=1, we=1, waddr==raddrN and raddrN!=0, drive rdataN = wdata in the same cycle; otherwise rdataN = rf[raddrN].
REQ-021 SHALL set pend[issue_addr] at the edge when issue_en=1 and issue_addr!=0.
REQ-022 SHALL clear pend[waddr] at the edge when we=1 and waddr!=0.
REQ-023 SHALL resolve set and clear on the same index in the same cycle as set wins (the new producer supersedes the retiring one).
REQ-024 SHALL clear all flags on flush=1, except that a same-cycle issue still sets its flag (flush applies first, then issue).
REQ-025 SHALL drive rbusyN = pend[raddrN], and when BYPASS=1 it SHALL be masked to 0 if we=1 and waddr==raddrN (data is being forwarded).
REQ-026 SHALL make pend_cnt equal the population count of pend, updated with the flags (registered, exact, and never exceeding NREG-1).
REQ-027 SHALL treat issue to an already pending index as idempotent: the flag stays 1 and the count is unchanged.
REQ-028 SHALL treat writeback to a non-pending index as a plain data write with no count change.

Reset
REQ-029 SHALL, on rst_n=0 and independent of clk, clear all data registers to 0, all pending flags to 0 and pend_cnt to 0.
REQ-030 SHALL make rdata1/2 = 0 and rbusy1/2 = 0 while reset is asserted.
REQ-031 SHALL ignore we, issue_en and flush while rst_n=0, and SHALL apply the first update at the first rising edge after deassertion.
REQ-032 SHALL let reset asserted mid-operation override any pending write or issue, with no partial update.

Verification
REQ-033 SHALL cover write then read: we=1, waddr=5, wdata=0xDEADBEEF, raddr1=5, BYPASS=1 -> rdata1=0xDEADBEEF in the same cycle; after the edge with we=0 -> still 0xDEADBEEF.
REQ-034 SHALL cover x0: we=1, waddr=0, wdata=0xFFFFFFFF plus issue_addr=0 -> rdata1(raddr1=0)=0, rbusy1=0, pend_cnt unchanged.
REQ-035 SHALL cover the scoreboard: issue 3, 7, 3 on consecutive cycles -> pend_cnt=2 and rbusy(3)=1; writeback 3 -> rbusy(3)=0 in the writeback cycle, pend_cnt=1 after the edge.
REQ-036 SHALL cover a collision: pend[9]=1, same cycle issue_addr=9 and we with waddr=9 -> after the edge pend[9]=1, pend_cnt unchanged, rf[9]=wdata.
REQ-037 SHALL cover flush with issue: 4 pending, flush=1 with issue_addr=12 -> after the edge only pend[12]=1, pend_cnt=1.
REQ-038 SHALL cover asynchronous reset: with registers loaded and 3 pending, drop rst_n between edges -> rdata=0, rbusy=0, pend_cnt=0 immediately; BYPASS=0 regression: same-cycle read of the written index returns the old value.
